traffic_lane: RTL and testbench

- Parametrised road lane for the LED-matrix crossing game; the successor to the single-cell car shifter.
- Holds a full row of WIDTH car cells and shifts them one cell per speed tick, in a configurable direction.
- Spawns cars from an LFSR bit, with a minimum-gap rule between cars.
- Counts cars leaving the lane and flags a sticky collision with the frog's column.
- One instance per road row; the top level wires the lanes to matrix rows and the LFSR.

---
 rtl/traffic_lane_if.sv | 28 ++
 rtl/traffic_lane.sv | 87 ++++++++
 tb/tb_traffic_lane.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_lane_if.sv
// Signal bundle between a traffic_lane and the game top level (or a bench).
// All inputs are sampled on clk; outputs are registered inside the lane.
interface traffic_lane_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH);

    logic             enable;
    logic             spawn_req;
    logic             frog_valid;
    logic [CW-1:0]    frog_col;
    logic             hit_clr;
    logic [WIDTH-1:0] lane_leds;
    logic             tick;
    logic             hit;
    logic [7:0]       cars_out;
    logic [7:0]       dbg_div_cnt;

    modport master (
        output enable, spawn_req, frog_valid, frog_col, hit_clr,
        input  lane_leds, tick, hit, cars_out, dbg_div_cnt
    );

    modport slave (
        input  enable, spawn_req, frog_valid, frog_col, hit_clr,
        output lane_leds, tick, hit, cars_out, dbg_div_cnt
    );
endinterface

// File: rtl/traffic_lane.sv
// One road row of the crossing game: shifting car cells, gated LFSR spawns,
// saturating exit counter and a sticky frog-collision flag.
module traffic_lane #(
    parameter int WIDTH   = 16,
    parameter int DIR     = 0,
    parameter int DIV     = 4,
    parameter int MIN_GAP = 2
) (
    input  logic          clk,
    input  logic          reset,
    traffic_lane_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    function automatic logic [WIDTH-1:0] gap_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MIN_GAP; i++) begin
            m[(DIR == 0) ? i : (WIDTH - 1 - i)] = 1'b1;
        end
        return m;
    endfunction

    // Entry-side cells that must be empty before a new car may appear.
    localparam logic [WIDTH-1:0] GAP_MASK = gap_mask();

    logic [CW-1:0]    r_div_cnt;
    logic [WIDTH-1:0] r_leds;
    logic             r_tick;
    logic             r_hit;
    logic [7:0]       r_cars;

    logic             w_tick_int;
    logic             w_spawn_ok;
    logic             w_exit;
    logic             w_hit_set;
    logic [WIDTH-1:0] w_shifted;

    assign w_tick_int = bus.enable && (r_div_cnt == CW'(DIV - 1));
    assign w_spawn_ok = bus.spawn_req && ((r_leds & GAP_MASK) == '0);

    generate
        if (DIR == 0) begin : g_up
            assign w_shifted = {r_leds[WIDTH-2:0], w_spawn_ok};
            assign w_exit    = r_leds[WIDTH-1];
        end else begin : g_down
            assign w_shifted = {w_spawn_ok, r_leds[WIDTH-1:1]};
            assign w_exit    = r_leds[0];
        end
    endgenerate

    // Out-of-range columns (possible when WIDTH is not a power of two) never hit.
    always_comb begin
        w_hit_set = 1'b0;
        if (bus.frog_valid && (32'(bus.frog_col) < WIDTH)) begin
            w_hit_set = r_leds[bus.frog_col];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_leds    <= '0;
            r_tick    <= 1'b0;
            r_hit     <= 1'b0;
            r_cars    <= 8'd0;
        end else begin
            r_tick <= w_tick_int;
            r_hit  <= w_hit_set | (r_hit & ~bus.hit_clr);
            if (bus.enable) begin
                r_div_cnt <= w_tick_int ? '0 : r_div_cnt + CW'(1);
            end
            if (w_tick_int) begin
                r_leds <= w_shifted;
                if (w_exit && (r_cars != 8'hFF)) begin
                    r_cars <= r_cars + 8'd1;
                end
            end
        end
    end

    assign bus.lane_leds   = r_leds;
    assign bus.tick        = r_tick;
    assign bus.hit         = r_hit;
    assign bus.cars_out    = r_cars;
    assign bus.dbg_div_cnt = 8'(r_div_cnt);
endmodule

// File: tb/tb_traffic_lane.sv
// Bench for traffic_lane: four differently parameterised lanes share one
// stimulus stream and are compared against a car-position reference model.
module tb_traffic_lane;
  localparam int NL = 4;
  localparam int P_W   [NL] = '{16, 16, 8, 10};
  localparam int P_DIR [NL] = '{0, 0, 1, 1};
  localparam int P_DIV [NL] = '{1, 1, 4, 3};
  localparam int P_GAP [NL] = '{0, 2, 0, 1};
  localparam int P_CW  [NL] = '{4, 4, 3, 4};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic s_en, s_spawn, s_fv, s_clr;
  int   s_col [NL];

  traffic_lane_if #(.WIDTH(16)) if0 ();
  traffic_lane_if #(.WIDTH(16)) if1 ();
  traffic_lane_if #(.WIDTH(8))  if2 ();
  traffic_lane_if #(.WIDTH(10)) if3 ();

  traffic_lane #(.WIDTH(16), .DIR(0), .DIV(1), .MIN_GAP(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  traffic_lane #(.WIDTH(16), .DIR(0), .DIV(1), .MIN_GAP(2)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  traffic_lane #(.WIDTH(8),  .DIR(1), .DIV(4), .MIN_GAP(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  traffic_lane #(.WIDTH(10), .DIR(1), .DIV(3), .MIN_GAP(1)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  assign if0.enable = s_en;  assign if0.spawn_req = s_spawn;  assign if0.frog_valid = s_fv;
  assign if1.enable = s_en;  assign if1.spawn_req = s_spawn;  assign if1.frog_valid = s_fv;
  assign if2.enable = s_en;  assign if2.spawn_req = s_spawn;  assign if2.frog_valid = s_fv;
  assign if3.enable = s_en;  assign if3.spawn_req = s_spawn;  assign if3.frog_valid = s_fv;
  assign if0.hit_clr = s_clr;  assign if1.hit_clr = s_clr;
  assign if2.hit_clr = s_clr;  assign if3.hit_clr = s_clr;
  assign if0.frog_col = 4'(s_col[0]);
  assign if1.frog_col = 4'(s_col[1]);
  assign if2.frog_col = 3'(s_col[2]);
  assign if3.frog_col = 4'(s_col[3]);

  // Reference model: occupancy indexed by distance travelled from the entry cell.
  bit m_occ  [NL][32];
  int m_cnt  [NL];
  int m_cars [NL];
  bit m_hit  [NL];
  bit m_tick [NL];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_leds(input int l);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < P_W[l]; i++)
      r[i] = m_occ[l][(P_DIR[l] == 0) ? i : (P_W[l] - 1 - i)];
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      for (int d = 0; d < 32; d++) m_occ[l][d] = 1'b0;
      m_cnt[l] = 0; m_cars[l] = 0; m_hit[l] = 1'b0; m_tick[l] = 1'b0;
    end
  endtask

  task automatic model_step(input int l);
    bit tk, hs, ok, ex;
    int w;
    logic [31:0] leds;
    w    = P_W[l];
    leds = m_leds(l);
    tk   = s_en && (m_cnt[l] == P_DIV[l] - 1);
    hs   = 1'b0;
    if (s_fv && s_col[l] < w) hs = leds[s_col[l]];
    if (tk) begin
      ex = m_occ[l][w-1];
      ok = s_spawn;
      for (int d = 0; d < P_GAP[l]; d++) if (m_occ[l][d]) ok = 1'b0;
      for (int d = w - 1; d > 0; d--) m_occ[l][d] = m_occ[l][d-1];
      m_occ[l][0] = ok;
      if (ex && m_cars[l] < 255) m_cars[l]++;
    end
    m_cnt[l]  = tk ? 0 : (s_en ? m_cnt[l] + 1 : m_cnt[l]);
    m_tick[l] = tk;
    m_hit[l]  = hs ? 1'b1 : (s_clr ? 1'b0 : m_hit[l]);
  endtask

  task automatic check_lane(input int l, input logic [31:0] leds, input logic tick,
                            input logic hit, input logic [7:0] cars, input logic [7:0] dcnt);
    chk($sformatf("L%0d.leds", l), leds, m_leds(l));
    chk($sformatf("L%0d.tick", l), 32'(tick), 32'(m_tick[l]));
    chk($sformatf("L%0d.hit", l),  32'(hit),  32'(m_hit[l]));
    chk($sformatf("L%0d.cars", l), 32'(cars), 32'(m_cars[l]));
    chk($sformatf("L%0d.div", l),  32'(dcnt), 32'(m_cnt[l]));
  endtask

  task automatic check_all();
    check_lane(0, 32'(if0.lane_leds), if0.tick, if0.hit, if0.cars_out, if0.dbg_div_cnt);
    check_lane(1, 32'(if1.lane_leds), if1.tick, if1.hit, if1.cars_out, if1.dbg_div_cnt);
    check_lane(2, 32'(if2.lane_leds), if2.tick, if2.hit, if2.cars_out, if2.dbg_div_cnt);
    check_lane(3, 32'(if3.lane_leds), if3.tick, if3.hit, if3.cars_out, if3.dbg_div_cnt);
  endtask

  task automatic drive(input bit en, input bit sp, input bit fv, input bit clr, input int col);
    s_en = en; s_spawn = sp; s_fv = fv; s_clr = clr;
    for (int l = 0; l < NL; l++) s_col[l] = col % (1 << P_CW[l]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else for (int l = 0; l < NL; l++) model_step(l);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  logic [31:0] gap_exp [7];

  initial begin
    gap_exp = '{32'h1, 32'h2, 32'h4, 32'h9, 32'h12, 32'h24, 32'h49};
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_leds", 32'(if0.lane_leds), 32'h0);
    chk("rst_cars", 32'(if0.cars_out), 32'h0);
    do_reset();

    // Single car across the 16-wide DIV=1 lane.
    drive(1, 1, 0, 0, 0);
    cycle();
    chk("seq0_first", 32'(if0.lane_leds), 32'h1);
    chk("seq0_tick", 32'(if0.tick), 32'h1);
    drive(1, 0, 0, 0, 0);
    for (int k = 2; k <= 17; k++) begin
      cycle();
      chk($sformatf("seq0_k%0d", k), 32'(if0.lane_leds), (k <= 16) ? (32'h1 << (k - 1)) : 32'h0);
    end
    chk("seq0_cars", 32'(if0.cars_out), 32'h1);

    // Held spawn against the MIN_GAP=2 lane (now empty).
    drive(1, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk($sformatf("gap_k%0d", k), 32'(if1.lane_leds), gap_exp[k]);
    end

    // Collision with a stationary frog at column 3.
    do_reset();
    drive(1, 1, 1, 0, 3);
    cycle();
    drive(1, 0, 1, 0, 3);
    for (int k = 2; k <= 17; k++) begin
      cycle();
      if (k == 4) chk("hit_before", 32'(if0.hit), 32'h0);
      if (k == 5) chk("hit_set", 32'(if0.hit), 32'h1);
    end
    chk("hit_sticky", 32'(if0.hit), 32'h1);
    drive(1, 0, 0, 1, 3);
    cycle();
    chk("hit_clr", 32'(if0.hit), 32'h0);
    drive(1, 1, 1, 1, 0);
    cycle();
    drive(1, 0, 1, 1, 0);
    cycle();
    chk("hit_set_wins", 32'(if0.hit), 32'h1);

    // Randomised run with pauses, spawns, frog moves and clears.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
      cycle();
    end

    // Saturation of the exit counter.
    do_reset();
    drive(1, 1, 1, 0, 5);
    for (int n = 0; n < 300; n++) cycle();
    chk("sat_cars", 32'(if0.cars_out), 32'd255);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_leds", 32'(if0.lane_leds), 32'h0);
    chk("async_cars", 32'(if0.cars_out), 32'h0);
    chk("async_hit", 32'(if0.hit), 32'h0);
    chk("async_tick", 32'(if0.tick), 32'h0);
    model_reset();
    @(negedge clk);
    cycle();
    reset = 1'b0;
    drive(1, 1, 0, 0, 0);
    for (int n = 0; n < 20; n++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
